// File: rtl/seq_monitor_pkg.sv
// seq_monitor_pkg
// Shared types and constants for the MSB phase-stream monitor.
//   state_t     : lock FSM encoding (UNLOCKED, LOCKED)
//   D_*         : modulo-4 phase delta classes
//   PHASE_W     : width of the phase bus
//   phase_delta : modulo-4 difference between two phase samples
package seq_monitor_pkg;

  localparam int PHASE_W = 2;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [PHASE_W-1:0] D_HOLD = 2'd0;
  localparam logic [PHASE_W-1:0] D_FWD  = 2'd1;
  localparam logic [PHASE_W-1:0] D_SKIP = 2'd2;
  localparam logic [PHASE_W-1:0] D_BACK = 2'd3;

  // Natural wrap of the 2-bit subtraction gives the modulo-4 step size.
  function automatic logic [PHASE_W-1:0] phase_delta(
    input logic [PHASE_W-1:0] cur,
    input logic [PHASE_W-1:0] prev
  );
    return cur - prev;
  endfunction

endpackage

// File: rtl/seq_monitor_sync_stages.sv
// sync_stages
// Parameterized bus synchronizer. DEPTH flops in series; DEPTH = 0 still
// registers the bus once so downstream timing is identical for same-domain
// sources. The bus must be Gray-coded or quasi-static when DEPTH > 0.
// Ports:
//   clk  : sampling clock
//   rst  : asynchronous active-low reset (all stages clear to 0)
//   d    : asynchronous/source-domain input bus
//   q    : synchronized output bus (last stage)
module sync_stages #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int N = (DEPTH < 1) ? 1 : DEPTH;

  logic [WIDTH-1:0] stage_r [N];

  // Shift chain: stage 0 samples the input, later stages follow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < N; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[N-1];

endmodule

// File: rtl/seq_monitor.sv
// seq_monitor
// Receive-side checker for the 2-bit MSB phase stream of a free-running
// counter. Synchronizes the phase, classifies each change as hold, legal
// advance or illegal jump, locks after LOCK_N consecutive advances and
// counts 11->00 wraps while locked.
// Optional feature macro: SEQ_MONITOR_DIR_EN -- accepts backward single
// steps (delta 3), counts 00->11 as a wrap decrement and adds port `dir`.
// Ports:
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-low reset
//   msbs_in    : phase from the counter
//   clr        : synchronous clear of wraps and err_sticky
//   phase      : synchronized phase
//   step       : pulse per legal advance while locked
//   wraps      : W-bit wrap counter (rolls over)
//   locked     : high in LOCKED
//   err        : pulse per illegal transition while locked
//   err_sticky : set by err, cleared by clr or reset
//   dir        : (SEQ_MONITOR_DIR_EN only) 1 = forward, 0 = backward
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int W           = 8,
  parameter int LOCK_N      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] msbs_in,
  input  logic               clr,
  output logic [PHASE_W-1:0] phase,
  output logic               step,
  output logic [W-1:0]       wraps,
  output logic               locked,
  output logic               err,
  output logic               err_sticky
`ifdef SEQ_MONITOR_DIR_EN
  ,
  output logic               dir
`endif
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_N - 1);

`ifdef SEQ_MONITOR_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  state_t             state_r;
  state_t             state_nxt_s;
  logic [RUN_W-1:0]   run_r;
  logic [RUN_W-1:0]   run_nxt_s;
  logic [PHASE_W-1:0] prev_r;
  logic               primed_r;
  logic [PHASE_W-1:0] delta_s;
  logic               adv_s;
  logic               back_s;
  logic               illegal_s;
  logic               step_nxt_s;
  logic               err_nxt_s;
  logic               wrap_inc_s;
  logic               wrap_dec_s;
`ifdef SEQ_MONITOR_DIR_EN
  logic               dir_nxt_s;
`endif

  sync_stages #(
    .WIDTH (PHASE_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (msbs_in),
    .q   (phase)
  );

  assign delta_s = phase_delta(phase, prev_r);

  // Classify the current phase change.
  always_comb begin
    adv_s     = 1'b0;
    back_s    = 1'b0;
    illegal_s = 1'b0;
    case (delta_s)
      D_HOLD: begin
        adv_s = 1'b0;
      end
      D_FWD: begin
        adv_s = 1'b1;
      end
      D_SKIP: begin
        illegal_s = 1'b1;
      end
      D_BACK: begin
        if (DIR_EN) begin
          adv_s  = 1'b1;
          back_s = 1'b1;
        end else begin
          illegal_s = 1'b1;
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Lock FSM next state, run counter and event decode.
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    step_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    wrap_inc_s  = 1'b0;
    wrap_dec_s  = 1'b0;
`ifdef SEQ_MONITOR_DIR_EN
    dir_nxt_s   = dir;
`endif
    if (!primed_r) begin
      // First evaluation after reset only loads prev.
      state_nxt_s = UNLOCKED;
    end else begin
      case (state_r)
        UNLOCKED: begin
          if (adv_s) begin
            // The LOCK_N-th advance locks but is not itself a step.
            if (run_r == RUN_LAST) begin
              state_nxt_s = LOCKED;
              run_nxt_s   = {RUN_W{1'b0}};
            end else begin
              run_nxt_s = run_r + RUN_W'(1);
            end
          end else if (illegal_s) begin
            run_nxt_s = {RUN_W{1'b0}};
          end else begin
            run_nxt_s = run_r;
          end
        end
        LOCKED: begin
          if (adv_s) begin
            step_nxt_s = 1'b1;
            wrap_inc_s = !back_s && (prev_r == 2'd3);
            wrap_dec_s = back_s && (prev_r == 2'd0);
`ifdef SEQ_MONITOR_DIR_EN
            dir_nxt_s  = !back_s;
`endif
          end else if (illegal_s) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = UNLOCKED;
            run_nxt_s   = {RUN_W{1'b0}};
          end else begin
            state_nxt_s = LOCKED;
          end
        end
        default: begin
          state_nxt_s = UNLOCKED;
          run_nxt_s   = {RUN_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state, history and pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= UNLOCKED;
      run_r    <= {RUN_W{1'b0}};
      prev_r   <= {PHASE_W{1'b0}};
      primed_r <= 1'b0;
      step     <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      run_r    <= run_nxt_s;
      prev_r   <= phase;
      primed_r <= 1'b1;
      step     <= step_nxt_s;
      err      <= err_nxt_s;
      locked   <= (state_nxt_s == LOCKED);
    end
  end

  // Wrap counter and sticky error; clr overrides same-cycle events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wraps      <= {W{1'b0}};
      err_sticky <= 1'b0;
    end else begin
      if (clr) begin
        wraps <= {W{1'b0}};
      end else if (wrap_inc_s) begin
        wraps <= wraps + W'(1);
      end else if (wrap_dec_s) begin
        wraps <= wraps - W'(1);
      end else begin
        wraps <= wraps;
      end
      if (clr) begin
        err_sticky <= 1'b0;
      end else if (err_nxt_s) begin
        err_sticky <= 1'b1;
      end else begin
        err_sticky <= err_sticky;
      end
    end
  end

`ifdef SEQ_MONITOR_DIR_EN
  // Direction flag, updated alongside step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir <= 1'b1;
    end else begin
      dir <= dir_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_seq_monitor.sv
// tb_seq_monitor
// Scoreboard bench for seq_monitor (W=8, LOCK_N=4, SYNC_STAGES=2).
// Stimulus pushes the expected step/err event into a queue; the monitor pops
// and compares whenever the DUT pulses step or err.
module tb_seq_monitor;

  logic       clk;
  logic       rst;
  logic [1:0] msbs_in;
  logic       clr;
  logic [1:0] phase;
  logic       step;
  logic [7:0] wraps;
  logic       locked;
  logic       err;
  logic       err_sticky;
`ifdef SEQ_MONITOR_DIR_EN
  logic       dir;
`endif

  typedef struct {
    logic       step;
    logic       err;
    logic [7:0] wraps;
    logic       locked;
    logic       sticky;
    logic       dir;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  seq_monitor #(
    .W           (8),
    .LOCK_N      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .msbs_in    (msbs_in),
    .clr        (clr),
    .phase      (phase),
    .step       (step),
    .wraps      (wraps),
    .locked     (locked),
    .err        (err),
    .err_sticky (err_sticky)
`ifdef SEQ_MONITOR_DIR_EN
    ,
    .dir        (dir)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_step(input logic [7:0] w, input logic sticky, input logic d);
    ev_t e;
    e.step = 1'b1; e.err = 1'b0; e.wraps = w; e.locked = 1'b1; e.sticky = sticky; e.dir = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [7:0] w);
    ev_t e;
    e.step = 1'b0; e.err = 1'b1; e.wraps = w; e.locked = 1'b0; e.sticky = 1'b1; e.dir = 1'b1;
    exp_q.push_back(e);
  endtask

  // Drive one phase value and hold it for a number of cycles.
  task automatic drive(input logic [1:0] v, input int hold);
    msbs_in = v;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  // Monitor: every step/err pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst && (step || err)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got step=%0d err=%0d wraps=%0d, expected no event",
                 step, err, wraps);
      end else begin
        ev_t e;
        logic ok;
        e = exp_q.pop_front();
        ok = (step === e.step) && (err === e.err) && (wraps === e.wraps) &&
             (locked === e.locked) && (err_sticky === e.sticky);
`ifdef SEQ_MONITOR_DIR_EN
        if (e.step) ok = ok && (dir === e.dir);
`endif
        if (!ok) begin
          n_bad++;
          $display("FAIL event: got step=%0d err=%0d wraps=%0d locked=%0d sticky=%0d, expected step=%0d err=%0d wraps=%0d locked=%0d sticky=%0d",
                   step, err, wraps, locked, err_sticky,
                   e.step, e.err, e.wraps, e.locked, e.sticky);
        end
      end
    end
  end

  initial begin
    logic [7:0] w;
    msbs_in = 2'd0;
    clr     = 1'b0;
    rst     = 1'b0;
    #3;
    chk("rst_phase", {30'd0, phase}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_wraps", {24'd0, wraps}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
`ifdef SEQ_MONITOR_DIR_EN
    chk("rst_dir", {31'd0, dir}, 32'd1);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    drive(2'd0, 8);

    // 1->3 skip clears the partial run; then 3->0,0->1,1->2,2->3 lock.
    drive(2'd1, 8);
    drive(2'd3, 8);
    chk("phase_follow", {30'd0, phase}, 32'd3);
    drive(2'd0, 8);
    drive(2'd1, 8);
    drive(2'd2, 8);
    chk("not_locked_3adv", {31'd0, locked}, 32'd0);
    drive(2'd3, 8);
    chk("locked_4th_adv", {31'd0, locked}, 32'd1);
    push_step(8'd1, 1'b0, 1'b1);
    drive(2'd0, 8);
    chk("wraps_first", {24'd0, wraps}, 32'd1);
    push_step(8'd1, 1'b0, 1'b1);
    drive(2'd1, 8);

    // Illegal 1->3 while locked.
    push_err(8'd1);
    drive(2'd3, 8);
    chk("err_unlock", {31'd0, locked}, 32'd0);
    chk("err_sticky_set", {31'd0, err_sticky}, 32'd1);
    chk("err_wraps_kept", {24'd0, wraps}, 32'd1);
    chk("err_gone", {31'd0, err}, 32'd0);

    // Relock after 4 advances.
    drive(2'd0, 8);
    drive(2'd1, 8);
    drive(2'd2, 8);
    chk("relock_pending", {31'd0, locked}, 32'd0);
    drive(2'd3, 8);
    chk("relock", {31'd0, locked}, 32'd1);

    // clr in the same cycle as a wrap: clr wins, step still pulses.
    push_step(8'd0, 1'b0, 1'b1);
    msbs_in = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("clr_wraps", {24'd0, wraps}, 32'd0);
    chk("clr_sticky", {31'd0, err_sticky}, 32'd0);
    chk("clr_keeps_lock", {31'd0, locked}, 32'd1);

    // 256 wraps at full rate: counter rolls 255 -> 0.
    for (int i = 1; i <= 256; i++) begin
      w = 8'(i - 1);
      push_step(w, 1'b0, 1'b1); drive(2'd1, 1);
      push_step(w, 1'b0, 1'b1); drive(2'd2, 1);
      push_step(w, 1'b0, 1'b1); drive(2'd3, 1);
      push_step(8'(i), 1'b0, 1'b1); drive(2'd0, 1);
    end
    drive(2'd0, 4);
    chk("rollover_wraps", {24'd0, wraps}, 32'd0);
    chk("rollover_no_err", {31'd0, err_sticky}, 32'd0);

    // Build wraps to 5, then reset asynchronously mid-cycle.
    for (int i = 1; i <= 5; i++) begin
      push_step(8'(i - 1), 1'b0, 1'b1); drive(2'd1, 1);
      push_step(8'(i - 1), 1'b0, 1'b1); drive(2'd2, 1);
      push_step(8'(i - 1), 1'b0, 1'b1); drive(2'd3, 1);
      push_step(8'(i), 1'b0, 1'b1); drive(2'd0, 1);
    end
    drive(2'd0, 4);
    chk("pre_rst_wraps", {24'd0, wraps}, 32'd5);
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_wraps", {24'd0, wraps}, 32'd0);
    chk("async_rst_locked", {31'd0, locked}, 32'd0);
    chk("async_rst_phase", {30'd0, phase}, 32'd0);
    chk("async_rst_step", {31'd0, step}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drive(2'd0, 4);
    drive(2'd1, 8);
    drive(2'd2, 8);
    drive(2'd3, 8);
    chk("post_rst_unlocked", {31'd0, locked}, 32'd0);
    drive(2'd0, 8);
    chk("post_rst_locked", {31'd0, locked}, 32'd1);
    chk("post_rst_wraps", {24'd0, wraps}, 32'd0);
    push_step(8'd0, 1'b0, 1'b1);
    drive(2'd1, 8);

`ifdef SEQ_MONITOR_DIR_EN
    // Backward 1->0->3: two backward steps, wraps 0 -> 255.
    push_step(8'd0, 1'b0, 1'b0);
    drive(2'd0, 8);
    push_step(8'd255, 1'b0, 1'b0);
    drive(2'd3, 8);
    chk("dir_locked", {31'd0, locked}, 32'd1);
    chk("dir_no_err", {31'd0, err_sticky}, 32'd0);
    chk("dir_wraps", {24'd0, wraps}, 32'd255);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
